// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the truth-table sequencer: FSM state encoding,
// number of input combinations swept and width of the captured table.
package truth_table_pkg;

  localparam int NUM_COMBOS = 8;
  localparam int RESULT_W   = 16;
  localparam int IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/truth_table_sequencer_dwell_timer.sv
// Dwell counter: counts DWELL enabled cycles and raises tick on the last one,
// then restarts from zero so consecutive indices follow with no gap.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Drives all eight {a,b,c} combinations into a combinational unit, holding each
// for DWELL cycles, and captures the {x,y} responses into a 16-bit truth table.
module truth_table_sequencer
  import truth_table_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                a,
  output logic                b,
  output logic                c,
  input  logic                x,
  input  logic                y,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] result
);

  state_t               state_q;
  state_t               state_d;
  logic [IDX_W-1:0]     idx_q;
  logic [RESULT_W-1:0]  result_q;
  logic                 tick;
  logic                 accept;
  logic                 sample;
  logic                 last_idx;
  logic                 drive_en;

  assign accept   = (state_q == IDLE) && start && !abort;
  assign drive_en = (state_q == DRIVE);
  assign sample   = drive_en && !abort && tick;
  assign last_idx = (idx_q == IDX_W'(NUM_COMBOS - 1));
  assign result   = result_q;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .en   (drive_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = DRIVE;
      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (tick && last_idx) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode registered state and index only, so stimulus is glitch-free.
  always_comb begin
    {a, b, c} = 3'b000;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      DRIVE: begin
        {a, b, c} = idx_q;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      idx_q    <= '0;
      result_q <= '0;
    end else if (sample) begin
      result_q[{idx_q, 1'b1}] <= x;
      result_q[{idx_q, 1'b0}] <= y;
      if (!last_idx) begin
        idx_q <= idx_q + 3'd1;
      end
    end else if ((state_q == DONE) || (drive_en && abort)) begin
      idx_q <= '0;
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a full-adder instance (DWELL=4) and an
// all-ones instance (DWELL=1), with a done-driven scoreboard per instance.
module tb_truth_table_sequencer;

  typedef struct {
    logic [15:0] res;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        start0, start1;
  logic        a0, b0, c0, x0, y0, busy0, done0;
  logic        a1, b1, c1, x1, y1, busy1, done1;
  logic [15:0] result0, result1;

  int   edge_cnt = 0;
  int   e0 = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  assign x0 = a0 ^ b0 ^ c0;
  assign y0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
  assign x1 = 1'b1;
  assign y1 = 1'b1;

  truth_table_sequencer #(.DWELL(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort),
    .a(a0), .b(b0), .c(c0), .x(x0), .y(y0),
    .busy(busy0), .done(done0), .result(result0)
  );

  truth_table_sequencer #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .a(a1), .b(b1), .c(c1), .x(x1), .y(y1),
    .busy(busy1), .done(done1), .result(result1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued sweep.
  always @(negedge clk) begin
    exp_t e;
    if (done0 === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL dut0 unexpected done at edge %0d, result %h", edge_cnt, result0);
      end else begin
        e = q0.pop_front();
        check("dut0 done cycle", 32'(edge_cnt), 32'(e.at));
        check("dut0 result", 32'(result0), 32'(e.res));
      end
    end
    if (done1 === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1 unexpected done at edge %0d, result %h", edge_cnt, result1);
      end else begin
        e = q1.pop_front();
        check("dut1 done cycle", 32'(edge_cnt), 32'(e.at));
        check("dut1 result", 32'(result1), 32'(e.res));
      end
    end
  end

  task automatic to_cycle(input int k);
    while (edge_cnt < e0 + k - 1) @(negedge clk);
  endtask

  task automatic start_dut0(input bit expect_done, input logic [15:0] res);
    exp_t e;
    start0 = 1'b1;
    e0 = edge_cnt + 1;
    if (expect_done) begin
      e.res = res;
      e.at  = e0 + 32;
      q0.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    check("scoreboard drained", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  task automatic check_idle0(input string name, input logic [15:0] res);
    check({name, " abc"}, 32'({a0, b0, c0}), 32'd0);
    check({name, " busy"}, 32'(busy0), 32'd0);
    check({name, " done"}, 32'(done0), 32'd0);
    check({name, " result"}, 32'(result0), 32'(res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge %0d", edge_cnt);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_idle0("reset", 16'h0000);
    check("reset dut1 result", 32'(result1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full-adder sweep with per-cycle stimulus timing.
    start_dut0(1'b1, 16'hD668);
    for (int k = 1; k <= 32; k++) begin
      to_cycle(k);
      check("sweep abc", 32'({a0, b0, c0}), 32'((k - 1) / 4));
      check("sweep busy", 32'(busy0), 32'd1);
    end
    to_cycle(33);
    check("done cycle abc", 32'({a0, b0, c0}), 32'd0);
    check("done cycle busy", 32'(busy0), 32'd0);
    to_cycle(34);
    check_idle0("after done", 16'hD668);
    to_cycle(40);
    check("result held", 32'(result0), 32'hD668);

    // Starts while busy are ignored.
    start_dut0(1'b1, 16'hD668);
    to_cycle(5);  start0 = 1'b1;
    to_cycle(6);  start0 = 1'b0;
    to_cycle(20); start0 = 1'b1;
    to_cycle(21); start0 = 1'b0;
    to_cycle(45);
    wait_drain();
    check_idle0("ignored starts", 16'hD668);

    // Abort mid-sweep keeps indices 0 and 1 only.
    start_dut0(1'b0, 16'h0000);
    to_cycle(10); abort = 1'b1;
    to_cycle(11); abort = 1'b0;
    check_idle0("abort", 16'h0008);
    to_cycle(45);
    check_idle0("abort settled", 16'h0008);

    // Start with abort in IDLE: abort wins.
    start0 = 1'b1; abort = 1'b1;
    @(negedge clk);
    start0 = 1'b0; abort = 1'b0;
    check_idle0("start+abort", 16'h0008);
    @(negedge clk);
    check("start+abort busy later", 32'(busy0), 32'd0);

    // Reset mid-sweep, then a fresh complete sweep.
    start_dut0(1'b0, 16'h0000);
    to_cycle(15); rst = 1'b1;
    to_cycle(16); rst = 1'b0;
    check_idle0("mid reset", 16'h0000);
    start_dut0(1'b1, 16'hD668);
    wait_drain();

    // DWELL=1 instance with x=y=1.
    start1 = 1'b1;
    e0 = edge_cnt + 1;
    e.res = 16'hFFFF;
    e.at  = e0 + 8;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    to_cycle(8);
    check("dwell1 last abc", 32'({a1, b1, c1}), 32'd7);
    check("dwell1 busy", 32'(busy1), 32'd1);
    wait_drain();
    check("dwell1 result held", 32'(result1), 32'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
